i2s_rx: RTL

I2S receiver: the inverse of the on-board I2S transmitter. It accepts BCK/LRCK/DIN from an external I2S source (ADC, codec or a second board on the GPIO header), running as a clock slave. It oversamples all three lines in the system clock domain and presents one parallel stereo sample pair per frame with a single-cycle strobe. It sits between the GPIO pins and the PCM datapath that feeds the DAC PWM and the SPDIF transmitter.

---
 rtl/i2s_rx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx : clock-slave I2S / left-justified receiver, stereo PCM out |
// | Option : define I2S_RX_ERR_EN to enable the bit-count error strobe |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module i2s_rx #(
  parameter int FMT  = 0,
  parameter int BITS = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            bck_i,
  input  logic            lrck_i,
  input  logic            din_i,
  output logic [BITS-1:0] left_o,
  output logic [BITS-1:0] right_o,
  output logic            valid_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [2:0]      bck_q;
  logic [1:0]      lrck_q;
  logic [1:0]      din_q;
  logic            rise_q;
  state_t          state_q, state_d;
  logic            lr_d1_q, lr_d1_d;
  logic            ws_prev_q, ws_prev_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [BITS-1:0] sr_q, sr_d;
  logic [BITS-1:0] lbuf_q, lbuf_d;
  logic [BITS-1:0] left_q, left_d;
  logic [BITS-1:0] right_q, right_d;
  logic            have_l_q, have_l_d;
  logic            valid_q, valid_d;
  logic            ws;
  logic            boundary;
  logic            commit_l;
  logic            commit_r;

  // bck_q[2] is the edge-detect history stage behind the two synchronizer flops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bck_q  <= '0;
      lrck_q <= '0;
      din_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      bck_q  <= {bck_q[1:0], bck_i};
      lrck_q <= {lrck_q[0], lrck_i};
      din_q  <= {din_q[0], din_i};
      rise_q <= bck_q[1] & ~bck_q[2];
    end
  end

  assign ws       = (FMT != 0) ? lrck_q[1] : lr_d1_q;
  assign boundary = rise_q && (ws != ws_prev_q);
  assign commit_l = boundary && !ws_prev_q && (state_q != ST_ARM);
  assign commit_r = boundary && ws_prev_q && (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    lr_d1_d   = lr_d1_q;
    ws_prev_d = ws_prev_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    lbuf_d    = lbuf_q;
    left_d    = left_q;
    right_d   = right_q;
    have_l_d  = have_l_q;
    valid_d   = 1'b0;

    if (rise_q) begin
      lr_d1_d = lrck_q[1];
      if (boundary) begin
        ws_prev_d      = ws;
        cnt_d          = 6'd1;
        sr_d           = '0;
        sr_d[BITS-1]   = din_q[1];
      end else begin
        // Bits past the word width fall off; unreceived LSBs stay zero
        for (int i = 0; i < BITS; i++) begin
          if (cnt_q == 6'(BITS - 1 - i)) sr_d[i] = din_q[1];
        end
        if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
      end
    end

    if (boundary && (state_q == ST_ARM)) state_d = ST_SYNC;

    if (commit_l) begin
      state_d  = ST_RUN;
      lbuf_d   = sr_q;
      have_l_d = 1'b1;
    end

    // Left is staged so both outputs move together with the strobe
    if (commit_r) begin
      right_d = sr_q;
      if (have_l_q) begin
        left_d   = lbuf_q;
        valid_d  = 1'b1;
        have_l_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_ARM;
      lr_d1_q   <= 1'b0;
      ws_prev_q <= 1'b0;
      cnt_q     <= '0;
      sr_q      <= '0;
      lbuf_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      have_l_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_d1_q   <= lr_d1_d;
      ws_prev_q <= ws_prev_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      lbuf_q    <= lbuf_d;
      left_q    <= left_d;
      right_q   <= right_d;
      have_l_q  <= have_l_d;
      valid_q   <= valid_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;

`ifdef I2S_RX_ERR_EN
  logic lerr_q, lerr_d;
  logic err_q, err_d;
  logic word_bad;

  always_comb begin
    word_bad = (cnt_q != 6'(BITS));
    lerr_d   = commit_l ? word_bad : lerr_q;
    err_d    = commit_r && (word_bad || (have_l_q && lerr_q));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lerr_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      lerr_q <= lerr_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire
